// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one memory-mapped UART transmitter between NumReq
// byte-stream requesters. It polls the UART status register, writes one byte
// to the TX register whenever the FIFO has room, and serves requesters
// round-robin. A requester keeps the grant until its whole message is sent.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   S_IDLE      | no owner; pick the next valid requester round-robin
//   S_STAT_REQ  | issue the status read (UartBase+8)
//   S_STAT_WAIT | wait for the status response; bit 0 = TX FIFO full
//   S_BACKOFF   | FIFO was full; count PollGap idle cycles before re-polling
//   S_WR_REQ    | write the owner's byte to UartBase+4 and pulse its ready
//   S_WR_WAIT   | wait for the write response; then keep or release the lock
module uart_tx_arbiter #(
    parameter int          NumReq      = 2,
    parameter logic [31:0] UartBase    = 32'h0002_0000,
    parameter int          PollGap     = 16,
    parameter int          LockTimeout = 1024,
    localparam int         GrantW      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumReq-1:0]     req_valid_i,
    input  logic [NumReq*8-1:0]   req_data_i,
    input  logic [NumReq-1:0]     req_last_i,
    output logic [NumReq-1:0]     req_ready_o,
    output logic                  uart_req_o,
    output logic [31:0]           uart_addr_o,
    output logic                  uart_we_o,
    output logic [3:0]            uart_be_o,
    output logic [31:0]           uart_wdata_o,
    input  logic                  uart_rvalid_i,
    input  logic [31:0]           uart_rdata_i,
    output logic [GrantW-1:0]     grant_o,
    output logic                  busy_o
);

    localparam int GapW  = (PollGap > 1) ? $clog2(PollGap) : 1;
    localparam int LockW = (LockTimeout > 1) ? $clog2(LockTimeout) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STAT_REQ,
        S_STAT_WAIT,
        S_BACKOFF,
        S_WR_REQ,
        S_WR_WAIT
    } state_t;

    state_t            r_state;
    logic [GrantW-1:0] r_grant;
    logic [GrantW-1:0] r_last_grant;
    logic              r_last_q;
    logic [GapW-1:0]   r_gap_cnt;
    logic [LockW-1:0]  r_lock_cnt;
    // Set once the write response has arrived and the owner has no next byte:
    // the lock is then held and the timeout counter is running.
    logic              r_hold;

    state_t            w_state_nxt;
    logic [GrantW-1:0] w_grant_nxt;
    logic [GrantW-1:0] w_last_grant_nxt;
    logic              w_last_q_nxt;
    logic [GapW-1:0]   w_gap_nxt;
    logic [LockW-1:0]  w_lock_nxt;
    logic              w_hold_nxt;

    logic [GrantW-1:0] w_pick;
    logic [GrantW-1:0] w_cand;
    logic              w_found;
    logic              w_own_valid;
    logic              w_own_last;
    logic [7:0]        w_own_data;
    logic              w_unused_rdata;

    assign grant_o        = r_grant;
    assign w_own_valid    = req_valid_i[r_grant];
    assign w_own_last     = req_last_i[r_grant];
    assign w_own_data     = req_data_i[{r_grant, 3'b000} +: 8];
    // Only the FIFO-full flag of the status word is meaningful here.
    assign w_unused_rdata = ^uart_rdata_i[31:1];

    // Round-robin search: first valid requester after the last grant, wrapping.
    always_comb begin
        w_pick  = r_last_grant;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 1; i <= NumReq; i++) begin
            w_cand = GrantW'((int'(r_last_grant) + i) % NumReq);
            if (!w_found && req_valid_i[w_cand]) begin
                w_pick  = w_cand;
                w_found = 1'b1;
            end
        end
    end

    // Next-state, next-register values and Moore-decoded bus outputs.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_last_q_nxt     = r_last_q;
        w_gap_nxt        = r_gap_cnt;
        w_lock_nxt       = r_lock_cnt;
        w_hold_nxt       = r_hold;
        uart_req_o       = 1'b0;
        uart_addr_o      = '0;
        uart_we_o        = 1'b0;
        uart_be_o        = '0;
        uart_wdata_o     = '0;
        req_ready_o      = '0;
        busy_o           = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt      = w_pick;
                    w_last_grant_nxt = w_pick;
                    w_state_nxt      = S_STAT_REQ;
                end
            end
            S_STAT_REQ: begin
                uart_req_o  = 1'b1;
                uart_be_o   = 4'b1111;
                uart_addr_o = UartBase + 32'd8;
                w_state_nxt = S_STAT_WAIT;
            end
            S_STAT_WAIT: begin
                if (uart_rvalid_i) begin
                    if (uart_rdata_i[0]) begin
                        w_gap_nxt   = GapW'(PollGap - 1);
                        w_state_nxt = S_BACKOFF;
                    end else begin
                        w_state_nxt = S_WR_REQ;
                    end
                end
            end
            S_BACKOFF: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_STAT_REQ;
                end else begin
                    w_gap_nxt = r_gap_cnt - GapW'(1);
                end
            end
            S_WR_REQ: begin
                uart_req_o           = 1'b1;
                uart_we_o            = 1'b1;
                uart_be_o            = 4'b0001;
                uart_addr_o          = UartBase + 32'd4;
                uart_wdata_o         = {24'd0, w_own_data};
                req_ready_o[r_grant] = 1'b1;
                w_last_q_nxt         = w_own_last;
                w_hold_nxt           = 1'b0;
                w_state_nxt          = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (!r_hold) begin
                    if (uart_rvalid_i) begin
                        if (r_last_q) begin
                            w_state_nxt = S_IDLE;
                        end else if (w_own_valid) begin
                            w_state_nxt = S_STAT_REQ;
                        end else begin
                            w_hold_nxt = 1'b1;
                            w_lock_nxt = LockW'(LockTimeout - 1);
                        end
                    end
                end else if (w_own_valid) begin
                    w_hold_nxt  = 1'b0;
                    w_state_nxt = S_STAT_REQ;
                end else if (r_lock_cnt == '0) begin
                    w_hold_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_lock_nxt = r_lock_cnt - LockW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= GrantW'(NumReq - 1);
            r_last_q     <= 1'b0;
            r_gap_cnt    <= '0;
            r_lock_cnt   <= '0;
            r_hold       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_last_q     <= w_last_q_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_lock_cnt   <= w_lock_nxt;
            r_hold       <= w_hold_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 2-requester and a 4-requester
// instance share one UART response model and one set of byte sources.
module tb_uart_tx_arbiter;

    localparam logic [31:0] Base = 32'h0002_0000;

    typedef struct {
        int          stamp;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  grant;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel4 = 1'b0;
    int   cyc = 0;
    int   t0 = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte sources (one per lane), shared by both instances through sel4.
    logic [7:0] src_data [4][8];
    logic       src_last [4][8];
    int         src_len  [4];
    int         src_idx  [4];
    logic       src_en   [4];
    logic [3:0]  s_valid;
    logic [3:0]  s_last;
    logic [31:0] s_data;

    always_comb begin
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        for (int k = 0; k < 4; k++) begin
            s_valid[k]      = src_en[k] && (src_idx[k] < src_len[k]);
            s_data[8*k +: 8] = src_data[k][src_idx[k] & 7];
            s_last[k]       = src_last[k][src_idx[k] & 7];
        end
    end

    // DUT signals
    logic [1:0]  rdy2;
    logic        req2, we2, busy2;
    logic [31:0] addr2, wdata2;
    logic [3:0]  be2;
    logic [0:0]  grant2;
    logic [3:0]  rdy4;
    logic        req4, we4, busy4;
    logic [31:0] addr4, wdata4;
    logic [3:0]  be4;
    logic [1:0]  grant4;
    logic        u_rvalid;
    logic [31:0] u_rdata;

    uart_tx_arbiter #(.NumReq(2), .UartBase(Base), .PollGap(16), .LockTimeout(12)) dut2 (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (sel4 ? 2'b00 : s_valid[1:0]),
        .req_data_i   (s_data[15:0]),
        .req_last_i   (s_last[1:0]),
        .req_ready_o  (rdy2),
        .uart_req_o   (req2),
        .uart_addr_o  (addr2),
        .uart_we_o    (we2),
        .uart_be_o    (be2),
        .uart_wdata_o (wdata2),
        .uart_rvalid_i(u_rvalid),
        .uart_rdata_i (u_rdata),
        .grant_o      (grant2),
        .busy_o       (busy2)
    );

    uart_tx_arbiter #(.NumReq(4), .UartBase(Base), .PollGap(16), .LockTimeout(12)) dut4 (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (sel4 ? s_valid : 4'b0000),
        .req_data_i   (s_data),
        .req_last_i   (s_last),
        .req_ready_o  (rdy4),
        .uart_req_o   (req4),
        .uart_addr_o  (addr4),
        .uart_we_o    (we4),
        .uart_be_o    (be4),
        .uart_wdata_o (wdata4),
        .uart_rvalid_i(u_rvalid),
        .uart_rdata_i (u_rdata),
        .grant_o      (grant4),
        .busy_o       (busy4)
    );

    logic        m_req, m_we, m_busy;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be, m_rdy;
    logic [1:0]  m_grant;

    assign m_req   = sel4 ? req4 : req2;
    assign m_we    = sel4 ? we4 : we2;
    assign m_addr  = sel4 ? addr4 : addr2;
    assign m_wdata = sel4 ? wdata4 : wdata2;
    assign m_be    = sel4 ? be4 : be2;
    assign m_rdy   = sel4 ? rdy4 : {2'b00, rdy2};
    assign m_grant = sel4 ? grant4 : {1'b0, grant2};
    assign m_busy  = sel4 ? busy4 : busy2;

    // Consume a source byte on each ready pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) src_idx[k] <= 0;
        end else begin
            for (int k = 0; k < 4; k++) if (m_rdy[k]) src_idx[k] <= src_idx[k] + 1;
        end
    end

    // UART model: response one cycle after each request; the first
    // full_reads status reads after reset report FIFO full.
    txn_t log_q[$];
    int   rdy_stamp[$];
    int   rdy_idx[$];
    int   stat_cnt = 0;
    int   full_reads = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            u_rvalid <= 1'b0;
            u_rdata  <= '0;
            stat_cnt <= 0;
        end else begin
            u_rvalid <= m_req;
            u_rdata  <= '0;
            if (m_req) begin
                log_q.push_back('{cyc, m_addr, m_we, m_be, m_wdata, m_grant});
                if (!m_we) begin
                    stat_cnt <= stat_cnt + 1;
                    if (stat_cnt < full_reads) u_rdata <= 32'd1;
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (m_rdy[k]) begin
                    rdy_stamp.push_back(cyc);
                    rdy_idx.push_back(k);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_txn(input string tag, input int i, input int st, input logic wr,
                           input logic [7:0] d, input logic [1:0] g);
        txn_t t;
        t = '{-1, '0, 1'b0, '0, '0, '0};
        if (i < log_q.size()) t = log_q[i];
        chk({tag, " stamp"}, t.stamp - t0, st);
        chk({tag, " addr"}, t.addr, wr ? Base + 32'd4 : Base + 32'd8);
        chk({tag, " we/be"}, {27'd0, t.we, t.be}, wr ? 32'h11 : 32'h0F);
        chk({tag, " wdata"}, t.wdata, wr ? {24'd0, d} : 32'd0);
        chk({tag, " grant"}, {30'd0, t.grant}, {30'd0, g});
    endtask

    task automatic chk_rdy(input string tag, input int i, input int st, input int k);
        int s, x;
        s = -1;
        x = -1;
        if (i < rdy_stamp.size()) begin
            s = rdy_stamp[i];
            x = rdy_idx[i];
        end
        chk({tag, " stamp"}, s - t0, st);
        chk({tag, " idx"}, x, k);
    endtask

    task automatic goto(input int c);
        while (cyc < t0 + c) @(negedge clk);
    endtask

    task automatic set_src(input int k, input int i, input logic [7:0] d, input logic l);
        src_data[k][i] = d;
        src_last[k][i] = l;
    endtask

    task automatic do_reset(input logic use4);
        @(negedge clk);
        rst  = 1'b1;
        sel4 = use4;
        full_reads = 0;
        for (int k = 0; k < 4; k++) begin
            src_en[k]  = 1'b0;
            src_len[k] = 0;
        end
        @(negedge clk);
        rst = 1'b0;
        log_q.delete();
        rdy_stamp.delete();
        rdy_idx.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int own, j, st;
        for (int k = 0; k < 4; k++) begin
            src_en[k]  = 1'b0;
            src_len[k] = 0;
            for (int i = 0; i < 8; i++) begin
                src_data[k][i] = '0;
                src_last[k][i] = 1'b0;
            end
        end

        // Reset values, asynchronous, before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst dut2 ctl", {22'd0, req2, we2, be2, rdy2, busy2, grant2}, 32'd0);
        chk("rst dut2 addr", addr2, 32'd0);
        chk("rst dut2 wdata", wdata2, 32'd0);
        chk("rst dut4 ctl", {19'd0, req4, we4, be4, rdy4, busy4, grant4}, 32'd0);
        chk("rst dut4 addr", addr4, 32'd0);
        chk("rst dut4 wdata", wdata4, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Test 1: single requester, two bytes, FIFO never full.
        do_reset(1'b0);
        set_src(0, 0, 8'h41, 1'b0);
        set_src(0, 1, 8'h42, 1'b1);
        src_len[0] = 2;
        src_en[0]  = 1'b1;
        t0 = cyc;
        goto(1);
        chk("t1 req c1", {31'd0, m_req}, 32'd1);
        goto(8);
        chk("t1 busy c8", {31'd0, m_busy}, 32'd1);
        goto(9);
        chk("t1 busy c9", {31'd0, m_busy}, 32'd0);
        chk("t1 ntxn", log_q.size(), 4);
        chk_txn("t1 rd0", 0, 1, 1'b0, 8'h00, 2'd0);
        chk_txn("t1 wr0", 1, 3, 1'b1, 8'h41, 2'd0);
        chk_txn("t1 rd1", 2, 5, 1'b0, 8'h00, 2'd0);
        chk_txn("t1 wr1", 3, 7, 1'b1, 8'h42, 2'd0);
        chk("t1 nrdy", rdy_stamp.size(), 2);
        chk_rdy("t1 rdy0", 0, 3, 0);
        chk_rdy("t1 rdy1", 1, 7, 0);

        // Test 2: two 3-byte messages requested together, no interleaving.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            set_src(0, i, 8'hA0 + 8'(i), i == 2);
            set_src(1, i, 8'hB0 + 8'(i), i == 2);
        end
        src_len[0] = 3;
        src_len[1] = 3;
        src_en[0]  = 1'b1;
        src_en[1]  = 1'b1;
        t0 = cyc;
        goto(25);
        chk("t2 busy c25", {31'd0, m_busy}, 32'd1);
        goto(26);
        chk("t2 busy c26", {31'd0, m_busy}, 32'd0);
        chk("t2 ntxn", log_q.size(), 12);
        for (int i = 0; i < 12; i++) begin
            own = i / 6;
            j   = i % 6;
            st  = (own == 1 ? 14 : 1) + 4 * (j / 2) + ((j % 2 == 1) ? 2 : 0);
            chk_txn($sformatf("t2 txn%0d", i), i, st, j % 2 == 1,
                    (own == 1 ? 8'hB0 : 8'hA0) + 8'(j / 2), 2'(own));
        end
        chk("t2 nrdy", rdy_stamp.size(), 6);
        for (int i = 0; i < 6; i++) begin
            own = i / 3;
            chk_rdy($sformatf("t2 rdy%0d", i), i, (own == 1 ? 16 : 3) + 4 * (i % 3), own);
        end

        // Test 3: FIFO full on two polls, PollGap=16.
        do_reset(1'b0);
        full_reads = 2;
        set_src(0, 0, 8'h55, 1'b1);
        src_len[0] = 1;
        src_en[0]  = 1'b1;
        t0 = cyc;
        goto(10);
        chk("t3 backoff c10", {30'd0, m_req, m_busy}, 32'd1);
        goto(40);
        chk("t3 busy c40", {31'd0, m_busy}, 32'd1);
        goto(41);
        chk("t3 busy c41", {31'd0, m_busy}, 32'd0);
        chk("t3 ntxn", log_q.size(), 4);
        chk_txn("t3 rd0", 0, 1, 1'b0, 8'h00, 2'd0);
        chk_txn("t3 rd1", 1, 19, 1'b0, 8'h00, 2'd0);
        chk_txn("t3 rd2", 2, 37, 1'b0, 8'h00, 2'd0);
        chk_txn("t3 wr", 3, 39, 1'b1, 8'h55, 2'd0);
        chk("t3 nrdy", rdy_stamp.size(), 1);
        chk_rdy("t3 rdy", 0, 39, 0);

        // Test 4: owner idles after a non-last byte; lock times out (12).
        do_reset(1'b0);
        set_src(0, 0, 8'hC0, 1'b0);
        set_src(0, 1, 8'hC1, 1'b1);
        set_src(1, 0, 8'hD0, 1'b1);
        src_len[0] = 2;
        src_len[1] = 1;
        src_en[0]  = 1'b1;
        src_en[1]  = 1'b1;
        t0 = cyc;
        goto(4);
        src_en[0] = 1'b0;
        goto(16);
        chk("t4 held c16", {29'd0, m_busy, m_grant}, 32'h4);
        goto(17);
        chk("t4 idle c17", {31'd0, m_busy}, 32'd0);
        goto(18);
        chk("t4 grant c18", {29'd0, m_busy, m_grant}, 32'h5);
        goto(21);
        src_en[0] = 1'b1;
        goto(26);
        chk("t4 busy c26", {31'd0, m_busy}, 32'd1);
        goto(27);
        chk("t4 busy c27", {31'd0, m_busy}, 32'd0);
        chk("t4 ntxn", log_q.size(), 6);
        chk_txn("t4 wrC0", 1, 3, 1'b1, 8'hC0, 2'd0);
        chk_txn("t4 rdD", 2, 18, 1'b0, 8'h00, 2'd1);
        chk_txn("t4 wrD0", 3, 20, 1'b1, 8'hD0, 2'd1);
        chk_txn("t4 wrC1", 5, 25, 1'b1, 8'hC1, 2'd0);
        chk("t4 nrdy", rdy_stamp.size(), 3);
        chk_rdy("t4 rdy1", 1, 20, 1);

        // Test 4b: owner re-raises valid before the timeout and keeps the lock.
        do_reset(1'b0);
        set_src(0, 0, 8'hC0, 1'b0);
        set_src(0, 1, 8'hC1, 1'b1);
        set_src(1, 0, 8'hD0, 1'b1);
        src_len[0] = 2;
        src_len[1] = 1;
        src_en[0]  = 1'b1;
        src_en[1]  = 1'b1;
        t0 = cyc;
        goto(4);
        src_en[0] = 1'b0;
        goto(8);
        src_en[0] = 1'b1;
        goto(18);
        chk("t4b busy c18", {31'd0, m_busy}, 32'd0);
        chk("t4b ntxn", log_q.size(), 6);
        chk_txn("t4b rdC", 2, 9, 1'b0, 8'h00, 2'd0);
        chk_txn("t4b wrC1", 3, 11, 1'b1, 8'hC1, 2'd0);
        chk_txn("t4b wrD0", 5, 16, 1'b1, 8'hD0, 2'd1);

        // Test 5: reset pulse inside STAT_WAIT without a clock edge.
        do_reset(1'b0);
        set_src(0, 0, 8'hE0, 1'b1);
        set_src(1, 0, 8'hF0, 1'b1);
        src_len[0] = 1;
        src_len[1] = 1;
        src_en[0]  = 1'b1;
        src_en[1]  = 1'b1;
        t0 = cyc;
        goto(2);
        chk("t5 busy c2", {31'd0, m_busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t5 async ctl", {22'd0, req2, we2, be2, rdy2, busy2, grant2}, 32'd0);
        chk("t5 async addr", addr2, 32'd0);
        #1 rst = 1'b0;
        goto(12);
        chk("t5 busy c12", {31'd0, m_busy}, 32'd0);
        chk("t5 ntxn", log_q.size(), 5);
        chk_txn("t5 rd re", 1, 3, 1'b0, 8'h00, 2'd0);
        chk_txn("t5 wrE0", 2, 5, 1'b1, 8'hE0, 2'd0);
        chk_txn("t5 wrF0", 4, 10, 1'b1, 8'hF0, 2'd1);
        chk("t5 nrdy", rdy_stamp.size(), 2);
        chk_rdy("t5 rdy0", 0, 5, 0);
        chk_rdy("t5 rdy1", 1, 10, 1);

        // Test 6: four requesters, single-byte messages, pointer wrap.
        do_reset(1'b1);
        set_src(0, 0, 8'h60, 1'b1);
        set_src(0, 1, 8'h64, 1'b1);
        set_src(1, 0, 8'h61, 1'b1);
        set_src(2, 0, 8'h62, 1'b1);
        set_src(3, 0, 8'h63, 1'b1);
        src_len[0] = 2;
        for (int k = 1; k < 4; k++) src_len[k] = 1;
        for (int k = 0; k < 4; k++) src_en[k] = 1'b1;
        t0 = cyc;
        goto(24);
        chk("t6 busy c24", {31'd0, m_busy}, 32'd1);
        goto(25);
        chk("t6 busy c25", {31'd0, m_busy}, 32'd0);
        chk("t6 ntxn", log_q.size(), 10);
        for (int m = 0; m < 5; m++) begin
            chk_txn($sformatf("t6 rd%0d", m), 2 * m, 1 + 5 * m, 1'b0, 8'h00, 2'(m % 4));
            chk_txn($sformatf("t6 wr%0d", m), 2 * m + 1, 3 + 5 * m, 1'b1, 8'h60 + 8'(m), 2'(m % 4));
        end
        chk("t6 nrdy", rdy_stamp.size(), 5);
        for (int m = 0; m < 5; m++) begin
            chk_rdy($sformatf("t6 rdy%0d", m), m, 3 + 5 * m, m % 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Bus-master controller that shares the single memory-mapped UART transmitter between `NumReq` byte-stream requesters (for example a core console path and a debug/boot message path). It drives the UART device port directly. It polls the UART status register and writes a byte to the TX register only when the TX FIFO is not full. Requesters are served round-robin with packet locking, so one requester's message (up to and including its `last` byte) is never interleaved with another's.

## Interface
Parameters:
- `NumReq`, 2: number of requesters, 2..8.
- `UartBase`, 32'h0002_0000: UART base address. The status register is at `UartBase+8`; the TX register is at `UartBase+4`.
- `PollGap`, 16: idle cycles between status polls while the UART FIFO reports full, ≥1.
- `LockTimeout`, 1024: cycles a locked requester may hold the grant with `valid` low before the lock is dropped, ≥1.

Ports:
- `clk_i`, in, 1: clock, the only clock.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `req_valid_i`, in, NumReq: byte available, per requester.
- `req_data_i`, in, NumReq*8: byte for requester k, at bits [8k+7:8k]. Held stable while valid.
- `req_last_i`, in, NumReq: byte is the last of a message. Qualified by valid.
- `req_ready_o`, out, NumReq: one-cycle pulse when the byte is consumed.
- `uart_req_o`, out, 1: device request, asserted for exactly one cycle per transaction.
- `uart_addr_o`, out, 32: device address.
- `uart_we_o`, out, 1: write enable.
- `uart_be_o`, out, 4: byte enables.
- `uart_wdata_o`, out, 32: write data.
- `uart_rvalid_i`, in, 1: response valid. The UART returns it exactly one cycle after each request.
- `uart_rdata_i`, in, 32: response data. Bit 0 of a status read = TX FIFO full.
- `grant_o`, out, $clog2(NumReq) (minimum width 1): index of the current owner.
- `busy_o`, out, 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, STAT_REQ, STAT_WAIT, BACKOFF, WR_REQ, WR_WAIT.
- IDLE:
  - If any `req_valid_i` is high, select an owner round-robin. The search starts at `(last_grant+1) mod NumReq`.
  - Register the owner in `grant_o`, set `last_grant`, and go to STAT_REQ.
- STAT_REQ:
  - Outputs: `uart_req_o=1`, `we=0`, `be=4'b1111`, `addr=UartBase+8`, `wdata=0`.
  - Next state: STAT_WAIT.
- STAT_WAIT:
  - Wait for `uart_rvalid_i`.
  - If `rdata[0]=1`, go to BACKOFF and load the gap counter with `PollGap-1`.
  - Otherwise, go to WR_REQ.
- BACKOFF: decrement the gap counter. At 0, go to STAT_REQ.
- WR_REQ:
  - Outputs: `uart_req_o=1`, `we=1`, `be=4'b0001`, `addr=UartBase+4`, `wdata={24'b0, owner byte}`, and `req_ready_o[owner]=1` in the same cycle.
  - Latch the owner's `req_last_i` into `last_q`.
  - Next state: WR_WAIT.
- WR_WAIT: wait for `uart_rvalid_i`, then:
  - If `last_q=1`, go to IDLE (lock released).
  - Else, if owner `valid=1`, go to STAT_REQ (lock held).
  - Else, hold in WR_WAIT with the lock held and count `LockTimeout` cycles. When owner `valid` rises, go to STAT_REQ. If the timeout expires, go to IDLE.
- Owner valid dropping in STAT_WAIT or BACKOFF is a protocol violation: `valid` must stay high until `ready`. The controller still issues the write with the current data.
- Only the owner ever sees `req_ready_o`. The other bits stay 0.
- Only one UART transaction is outstanding at any time.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE, `last_grant=NumReq-1` (so requester 0 wins first), `grant_o=0`, `last_q=0`, counters 0.
  - All outputs 0: `uart_req_o`, `uart_we_o`, `uart_be_o`, `uart_addr_o`, `uart_wdata_o`, `req_ready_o`, `busy_o`.
- Reset mid-transaction abandons it. No `ready` is issued for the byte in flight, and the requester must re-present it.
- Outputs are decoded from the registered state (Moore). `uart_*` outputs are 0 outside STAT_REQ and WR_REQ.
- Latency, with valid rising in IDLE at cycle 0:
  - STAT_REQ at cycle 1, rvalid at cycle 2.
  - WR_REQ with `ready` at cycle 3, rvalid at cycle 4.
  - Next STAT_REQ at cycle 5, so sustained throughput is 1 byte per 4 cycles when the UART is not full.
- Each full poll adds `PollGap+2` cycles.
- An `uart_rvalid_i` outside STAT_WAIT or WR_WAIT is ignored.
- Round-robin pointer wraps from `NumReq-1` to 0.
- Simultaneous valids: the requester closest after `last_grant` wins. The others wait until the owner's message ends or its lock times out.

## Test plan
- Single requester 0, bytes 0x41 0x42 (with last), FIFO never full → UART sequence: rd 0x20008, wr 0x20004=0x41, rd, wr=0x42. `ready` pulses at cycles 3 and 7. `busy_o` low at cycle 9.
- Requesters 0 and 1 valid together, each sending a 3-byte message → all 3 bytes of req 0 are written, then all 3 of req 1. No interleaving. `grant_o` goes 0 then 1.
- Status returns full=1 twice, then 0, with `PollGap=16` → 3 status reads spaced 18 cycles apart, then one write. `ready` pulses exactly once.
- Owner drops valid after a non-last byte for `LockTimeout+5` cycles while req 1 is valid → req 1 is granted only after exactly `LockTimeout` cycles. Re-raising valid before the timeout resumes req 0 instead.
- `rst_i` pulsed during STAT_WAIT, in a cycle without a clock edge → all outputs 0 immediately. After release, requester 0 wins first and no stale `ready` appears.
- `NumReq=4`, all valid, single-byte messages → grant order 0,1,2,3,0 (wrap-around check).
